// File: rtl/uart_packet_rx_pkg.sv
// Shared encodings and defaults for the UART packet receiver.
// Byte and packet FSM states plus default framing constants.
package uart_packet_rx_pkg;

  localparam int          DEF_CLKS_PER_BIT = 2604;
  localparam logic [7:0]  DEF_STX          = 8'h02;
  localparam logic [7:0]  DEF_ETX          = 8'h03;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_RECV,
    P_DONE
  } pkt_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser with input synchroniser and mid-bit sampling.
// byte_valid / byte_ferr pulse during the clk that samples the stop bit.
module uart_rx_byte
  import uart_packet_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_ferr,
  output logic       byte_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_q;
  byte_state_e   state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;

  assign rx_s = sync[1];

  // Line idles high, so the synchroniser resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      rx_q    <= 1'b1;
      state   <= B_IDLE;
      timer   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      sync    <= {sync[0], rxd};
      rx_q    <= rx_s;
      state   <= state_n;
      timer   <= timer_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    byte_valid = 1'b0;
    byte_ferr  = 1'b0;
    unique case (state)
      B_IDLE: begin
        timer_n = '0;
        if (rx_q && !rx_s) begin
          state_n   = B_START;
          bit_cnt_n = '0;
        end
      end
      B_START: begin
        if (timer == HALF_END) begin
          timer_n = '0;
          state_n = rx_s ? B_IDLE : B_DATA;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      B_DATA: begin
        if (timer == BIT_END) begin
          timer_n   = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = B_STOP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      B_STOP: begin
        if (timer == BIT_END) begin
          timer_n    = '0;
          state_n    = B_IDLE;
          byte_valid = rx_s;
          byte_ferr  = !rx_s;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = B_IDLE;
    endcase
  end

  assign byte_data = shreg;
  assign byte_busy = (state != B_IDLE);

endmodule

// File: rtl/uart_packet_rx.sv
// STX|payload|ETX packet framer on top of the 8N1 byte receiver.
// Payload leaves on a valid/ready port; framing faults pulse err_* outputs.
module uart_packet_rx
  import uart_packet_rx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int          PKT_BYTES    = 8,
  parameter logic [7:0]  STX          = DEF_STX,
  parameter logic [7:0]  ETX          = DEF_ETX,
  parameter int          TIMEOUT_CLKS = 500000,
  localparam int         PW           = (PKT_BYTES - 2) * 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxd,
  output logic [PW-1:0] pkt_data,
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output logic          err_frame,
  output logic          err_marker,
  output logic          err_timeout,
  output logic          err_overrun,
  output logic          busy
);

  localparam int IW = $clog2(PKT_BYTES);
  localparam int GW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IW-1:0] LAST    = IW'(PKT_BYTES - 1);
  localparam logic [GW-1:0] GAP_END = GW'(TIMEOUT_CLKS - 1);

  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ferr;
  logic          byte_busy;

  pkt_state_e    pstate, pstate_n;
  logic [IW-1:0] idx, idx_n;
  logic [GW-1:0] gap, gap_n;
  logic [PW-1:0] asm_q, asm_n;
  logic [PW-1:0] data_n;
  logic          valid_n;
  logic          frame_n, marker_n, timeout_n, overrun_n;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ferr (byte_ferr),
    .byte_busy (byte_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate      <= P_IDLE;
      idx         <= '0;
      gap         <= '0;
      asm_q       <= '0;
      pkt_data    <= '0;
      pkt_valid   <= 1'b0;
      err_frame   <= 1'b0;
      err_marker  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      pstate      <= pstate_n;
      idx         <= idx_n;
      gap         <= gap_n;
      asm_q       <= asm_n;
      pkt_data    <= data_n;
      pkt_valid   <= valid_n;
      err_frame   <= frame_n;
      err_marker  <= marker_n;
      err_timeout <= timeout_n;
      err_overrun <= overrun_n;
    end
  end

  always_comb begin
    pstate_n  = pstate;
    idx_n     = idx;
    gap_n     = gap;
    asm_n     = asm_q;
    data_n    = pkt_data;
    valid_n   = pkt_valid;
    frame_n   = 1'b0;
    marker_n  = 1'b0;
    timeout_n = 1'b0;
    overrun_n = 1'b0;
    if (pkt_valid && pkt_ready) valid_n = 1'b0;
    unique case (pstate)
      P_IDLE: begin
        gap_n = '0;
        idx_n = '0;
        if (byte_ferr) begin
          frame_n = 1'b1;
        end else if (byte_valid) begin
          if (byte_data == STX) begin
            pstate_n = P_RECV;
            idx_n    = IW'(1);
          end else begin
            marker_n = 1'b1;
          end
        end
      end
      P_RECV: begin
        if (byte_ferr) begin
          frame_n  = 1'b1;
          pstate_n = P_IDLE;
        end else if (byte_valid) begin
          gap_n = '0;
          if (idx == LAST) begin
            if (byte_data == ETX) begin
              pstate_n = P_DONE;
            end else begin
              marker_n = 1'b1;
              pstate_n = P_IDLE;
            end
          end else begin
            // Shift right so the first payload byte ends up in [7:0].
            asm_n = PW'({byte_data, asm_q} >> 8);
            idx_n = idx + 1'b1;
          end
        end else if (!byte_busy) begin
          if (gap == GAP_END) begin
            timeout_n = 1'b1;
            pstate_n  = P_IDLE;
          end else begin
            gap_n = gap + 1'b1;
          end
        end
      end
      P_DONE: begin
        pstate_n = P_IDLE;
        if (!pkt_valid || pkt_ready) begin
          data_n  = asm_q;
          valid_n = 1'b1;
        end else begin
          overrun_n = 1'b1;
        end
      end
      default: pstate_n = P_IDLE;
    endcase
  end

  assign busy = byte_busy || (pstate != P_IDLE);

endmodule
